// File: rtl/sram_frame_writer_pkg.sv
// rtl/sram_frame_writer_pkg.sv - shared types and constants for the SRAM frame writer
package sram_frame_writer_pkg;

    localparam int FRAME_WORDS_DEFAULT = 1048576;
    localparam int SRAM_ADDR_W         = 20;
    localparam int PIX_W               = 16;
    localparam int FIFO_W              = PIX_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOF = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_DONE     = 3'd4
    } fsm_state_e;

    // One buffered pixel: start-of-frame flag above the 16-bit word
    typedef struct packed {
        logic             sof;
        logic [PIX_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sram_frame_writer_if.sv
// rtl/sram_frame_writer_if.sv - pixel stream handshake between a source and the frame writer
interface sram_frame_writer_if;
    import sram_frame_writer_pkg::*;

    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             pix_sof;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_sof,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_sof,
        output pix_ready
    );

endinterface

// File: rtl/frame_fifo.sv
// rtl/frame_fifo.sv - small synchronous FIFO with registered full/empty flags
module frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             full_q;
    logic             empty_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    // Occupancy after this cycle; a simultaneous push and pop cancel out
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // Pointers, occupancy and flags; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == (PTR_W+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage array, no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sram_frame_writer.sv
// rtl/sram_frame_writer.sv - captures one pixel frame from a stream into an asynchronous SRAM
module sram_frame_writer
    import sram_frame_writer_pkg::*;
#(
    parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk108,
    input  logic                   rst,
    input  logic                   start,
    sram_frame_writer_if.slave     pix,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [PIX_W-1:0]       sram_dq_out,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n,
    output logic                   we_nOUT,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_err
);

    localparam logic [SRAM_ADDR_W-1:0] LAST_ADDR = SRAM_ADDR_W'(FRAME_WORDS - 1);

    fsm_state_e             state_q;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic                   we_n_q;
    logic                   we_nout_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;

    logic [FIFO_W-1:0]      head_raw;
    fifo_entry_t            head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic                   resync;

    frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk108),
        .rst_n   (rst),
        .push_i  (pix.pix_valid),
        .wdata_i ({pix.pix_sof, pix.pix_data}),
        .pop_i   (fifo_pop),
        .rdata_o (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head          = head_raw;
    assign pix.pix_ready = !fifo_full;

    // A start-of-frame arriving mid-frame restarts the frame at address 0
    assign resync = (state_q == ST_WR_SETUP) && !fifo_empty && head.sof && (addr_q != '0);

    // FIFO pop: drain in IDLE, skip non-sof in WAIT_SOF, retire the written word in WR_PULSE
    always_comb begin
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE:     fifo_pop = !fifo_empty;
            ST_WAIT_SOF: fifo_pop = !fifo_empty && !head.sof;
            ST_WR_PULSE: fifo_pop = 1'b1;
            default:     fifo_pop = 1'b0;
        endcase
    end

    // SRAM bus: the head word is presented from the setup cycle and held through the pulse
    always_comb begin
        sram_dq_oe  = ((state_q == ST_WR_SETUP) && !fifo_empty) || (state_q == ST_WR_PULSE);
        sram_dq_out = sram_dq_oe ? head.data : '0;
        sram_addr   = resync ? '0 : addr_q;
    end

    assign sram_we_n  = we_n_q;
    assign sram_ce_n  = 1'b0;
    assign sram_ub_n  = 1'b0;
    assign sram_lb_n  = 1'b0;
    assign sram_oe_n  = ~we_nout_q;
    assign we_nOUT    = we_nout_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

    // Capture FSM with registered strobes; we_nOUT/busy change together with the state they describe
    always_ff @(posedge clk108 or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            we_n_q    <= 1'b1;
            we_nout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_WAIT_SOF;
                        we_nout_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_WAIT_SOF: begin
                    if (!fifo_empty && head.sof) begin
                        state_q <= ST_WR_SETUP;
                        addr_q  <= '0;
                    end
                end
                ST_WR_SETUP: begin
                    if (!fifo_empty) begin
                        state_q <= ST_WR_PULSE;
                        we_n_q  <= 1'b0;
                        if (resync) begin
                            err_q  <= 1'b1;
                            addr_q <= '0;
                        end
                    end
                end
                ST_WR_PULSE: begin
                    we_n_q <= 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_q   <= ST_DONE;
                        addr_q    <= '0;
                        done_q    <= 1'b1;
                        we_nout_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        state_q <= ST_WR_SETUP;
                        addr_q  <= addr_q + SRAM_ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_frame_writer.sv
// tb/tb_sram_frame_writer.sv - directed self-checking bench for sram_frame_writer
module tb_sram_frame_writer;

    logic        clk108 = 1'b0;
    logic        rst    = 1'b0;
    logic        start  = 1'b0;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe, sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;
    logic        we_nOUT, busy, frame_done, frame_err;

    sram_frame_writer_if pix ();

    sram_frame_writer #(
        .FRAME_WORDS (16),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk108      (clk108),
        .rst         (rst),
        .start       (start),
        .pix         (pix),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n),
        .we_nOUT     (we_nOUT),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 clk108 = ~clk108;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [19:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          wr_cyc_q  [$];
    logic [19:0] exp_addr_q [$];
    logic [15:0] exp_data_q [$];
    int          low_run  = 0;
    int          max_run  = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          err_cnt  = 0;
    int          xfer_cyc = 0;
    int          first_xfer = 0;
    int          g;
    logic        saw_full = 1'b0;

    always @(posedge clk108) cyc <= cyc + 1;

    always @(negedge clk108) begin
        if (rst) begin
            if (!sram_we_n) begin
                wr_addr_q.push_back(sram_addr);
                wr_data_q.push_back(sram_dq_out);
                wr_cyc_q.push_back(cyc);
                low_run = low_run + 1;
                if (low_run > max_run) max_run = low_run;
            end else begin
                low_run = 0;
            end
            if (frame_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (frame_err) err_cnt = err_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk108);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic s);
        int guard;
        pix.pix_valid = 1'b1;
        pix.pix_data  = d;
        pix.pix_sof   = s;
        guard = 0;
        while (!pix.pix_ready && guard < 50) begin
            saw_full = 1'b1;
            step();
            guard++;
        end
        check("send_ready_timeout", 32'(guard < 50), 1);
        xfer_cyc = cyc;
        step();
    endtask

    task automatic idle_in();
        pix.pix_valid = 1'b0;
        pix.pix_sof   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, wr_addr_q.size(), exp_addr_q.size());
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(exp_addr_q[i]));
            check($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[i]), 32'(exp_data_q[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        pix.pix_valid = 1'b0;
        pix.pix_data  = '0;
        pix.pix_sof   = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();

        check("rst_we_n", sram_we_n, 1);
        check("rst_we_nOUT", we_nOUT, 1);
        check("rst_ready", pix.pix_ready, 1);
        check("rst_addr", sram_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_oe_n", sram_oe_n, 0);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_dq_out", sram_dq_out, 0);
        check("rst_ce_ub_lb", {sram_ce_n, sram_ub_n, sram_lb_n}, 0);
        check("rst_pulses", {frame_done, frame_err}, 0);

        send(16'h1234, 1'b1);
        send(16'h5678, 1'b0);
        idle_in();
        repeat (4) step();
        check("idle_no_write", wr_addr_q.size(), 0);
        check("idle_busy", busy, 0);
        check("idle_ready", pix.pix_ready, 1);

        pulse_start();
        check("start_busy", busy, 1);
        check("start_we_nOUT", we_nOUT, 0);
        check("start_oe_n", sram_oe_n, 1);
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        send(16'h3333, 1'b0);
        send(16'hA55A, 1'b1);
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        idle_in();
        repeat (10) step();
        exp_addr_q = '{20'd0, 20'd1, 20'd2};
        exp_data_q = '{16'hA55A, 16'h0001, 16'h0002};
        check_writes("sof");
        check("setup_addr", sram_addr, 3);
        check("setup_dq_oe_empty", sram_dq_oe, 0);
        check("setup_we_n", sram_we_n, 1);

        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(16'h0100 + 16'(i), 1'b0);
            if (i == 0) first_xfer = xfer_cyc;
            exp_addr_q.push_back(20'(3 + i));
            exp_data_q.push_back(16'h0100 + 16'(i));
        end
        idle_in();
        repeat (20) step();
        check("burst_ready_low", saw_full, 1);
        check("burst_count", wr_addr_q.size(), 11);
        if (wr_cyc_q.size() >= 11) begin
            check("latency", wr_cyc_q[3] - first_xfer, 2);
            for (int k = 3; k < 10; k++) begin
                check($sformatf("interval%0d", k), wr_cyc_q[k+1] - wr_cyc_q[k], 2);
            end
        end

        for (int i = 0; i < 5; i++) begin
            send(16'h0200 + 16'(i), 1'b0);
            exp_addr_q.push_back(20'(11 + i));
            exp_data_q.push_back(16'h0200 + 16'(i));
        end
        idle_in();
        g = 0;
        while (done_cnt == 0 && g < 100) begin
            step();
            g++;
        end
        repeat (4) step();
        check("done_count", done_cnt, 1);
        check_writes("frame");
        if (wr_cyc_q.size() == 16) check("done_after_last", done_cyc, wr_cyc_q[15] + 1);
        check("we_n_pulse_len", max_run, 1);
        check("done_addr", sram_addr, 0);
        check("done_we_nOUT", we_nOUT, 1);
        check("done_busy", busy, 0);
        check("frame_no_err", err_cnt, 0);

        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        pulse_start();
        send(16'hB000, 1'b1);
        send(16'hB001, 1'b0);
        send(16'hB002, 1'b0);
        send(16'hB003, 1'b0);
        send(16'hB004, 1'b0);
        send(16'hC000, 1'b1);
        send(16'hC001, 1'b0);
        idle_in();
        repeat (12) step();
        exp_addr_q = '{20'd0, 20'd1, 20'd2, 20'd3, 20'd4, 20'd0, 20'd1};
        exp_data_q = '{16'hB000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hC000, 16'hC001};
        check("err_count", err_cnt, 1);
        check_writes("resync");
        check("resync_addr", sram_addr, 2);
        check("resync_no_done", done_cnt, 1);

        send(16'hC002, 1'b0);
        idle_in();
        g = 0;
        while (sram_we_n === 1'b1 && g < 10) begin
            step();
            g++;
        end
        check("pulse_seen", sram_we_n, 0);
        rst = 1'b0;
        #1;
        check("async_we_n", sram_we_n, 1);
        check("async_dq_oe", sram_dq_oe, 0);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("post_rst_busy", busy, 0);
        check("post_rst_we_nOUT", we_nOUT, 1);
        check("post_rst_addr", sram_addr, 0);
        check("post_rst_ready", pix.pix_ready, 1);
        check("post_rst_oe_n", sram_oe_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_frame_writer.md
SRAM_FRAME_WRITER -- requirements
Module: sram_frame_writer

Interface
REQ-001 Parameter FRAME_WORDS, default 1048576, meaning words per frame (1024x1024, one 16-bit word per pixel).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning input FIFO entries (power of two).
REQ-003 clk108  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to capture the next frame.
REQ-006 pix_valid  in  1  input pixel valid.
REQ-007 pix_ready  out  1  FIFO can accept a pixel.
REQ-008 pix_data  in  16  pixel word; [15:8] red byte, [7:0] blue byte.
REQ-009 pix_sof  in  1  qualifies pix_data as the first pixel of a frame.
REQ-010 sram_addr  out  20  SRAM word address.
REQ-011 sram_dq_out  out  16  SRAM write data.
REQ-012 sram_dq_oe  out  1  drive enable for the SRAM DQ bus.
REQ-013 sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active-low.
REQ-014 we_nOUT  out  1  display permission to the SRAM reader; 1 = reader owns SRAM.
REQ-015 busy  out  1  capture in progress.
REQ-016 frame_done  out  1  one-cycle pulse after the last word is written.
REQ-017 frame_err  out  1  one-cycle pulse on an unexpected pix_sof mid-frame.

Function
REQ-018 Handshake: a transfer occurs on a cycle with pix_valid=1 and pix_ready=1; pix_ready = FIFO not full, in every state.
REQ-019 FSM states: IDLE, WAIT_SOF, WR_SETUP, WR_PULSE, DONE.
REQ-020 IDLE: accepted pixels are discarded; start=1 -> WAIT_SOF; we_nOUT=1.
REQ-021 WAIT_SOF: FIFO-head entries with sof=0 are popped and discarded, one per cycle; head with sof=1 -> WR_SETUP with address 0.
REQ-022 WR_SETUP: FIFO head nonempty -> drive sram_addr and sram_dq_out, sram_dq_oe=1, sram_we_n=1, then go to WR_PULSE; FIFO empty -> remain in WR_SETUP with sram_dq_oe=0.
REQ-023 WR_PULSE: sram_we_n=0 for exactly one cycle; addr and data held stable; entry popped at the end of the cycle; address increments.
REQ-024 Throughput: one word per 2 cycles maximum; minimum latency from a transfer to the we_n-low cycle with an empty FIFO is 2 cycles.
REQ-025 The word written at address FRAME_WORDS-1 -> DONE; address wraps to 0 (20-bit natural wrap).
REQ-026 DONE: frame_done=1 for one cycle, then IDLE.
REQ-027 A head entry with sof=1 in WR_SETUP at address != 0 -> frame_err pulse, address reset to 0, and that pixel written at address 0 (resynchronise).
REQ-028 start while not in IDLE is ignored.
REQ-029 we_nOUT=0 and busy=1 in WAIT_SOF, WR_SETUP, WR_PULSE; otherwise we_nOUT=1 and busy=0; we_nOUT is registered.
REQ-030 sram_ce_n=0, sram_ub_n=0, sram_lb_n=0 always; sram_oe_n=1 whenever we_nOUT=0, else 0.
REQ-031 Simultaneous push and pop on a full FIFO is allowed only because pix_ready is low when full; a push and pop in the same cycle leaves the count unchanged.

Reset
REQ-032 Reset returns the FSM to IDLE, the FIFO to empty, sram_addr to 0, sram_dq_out to 0, sram_dq_oe to 0, sram_we_n to 1, sram_oe_n to 0, we_nOUT to 1, busy to 0, frame_done to 0, and frame_err to 0.
REQ-033 Reset mid-write forces sram_we_n=1 asynchronously; the partial frame is abandoned.

Structure
REQ-034 A shared package holds the FSM state encoding, FRAME_WORDS, the SRAM address width (20), and the pixel width (16).
REQ-035 One sub-module, frame_fifo (17-bit wide: sof plus data, FIFO_DEPTH deep, registered full/empty), implements the input buffer.

Verification
REQ-036 Reset then idle: sram_we_n=1, we_nOUT=1, pix_ready=1, sram_addr=0.
REQ-037 start, 3 junk pixels, then sof pixel 16'hA55A plus 2 pixels: junk discarded; writes at addresses 0,1,2 with data 16'hA55A onward; each we_n low pulse lasts 1 cycle.
REQ-038 Continuous pix_valid: pix_ready deasserts when 4 entries are held; no pixel is lost or duplicated; one write every 2 cycles.
REQ-039 Full frame with FRAME_WORDS overridden to 16: frame_done pulses once after address 15, sram_addr returns to 0, we_nOUT returns to 1.
REQ-040 sof injected at pixel 5: frame_err pulses once and that pixel is written at address 0.
REQ-041 rst low during WR_PULSE: sram_we_n rises immediately; after release the block is in IDLE with we_nOUT=1.
